// File: rtl/stack_arbiter_if.sv
// Pin bundle between stack_arbiter, its two requesters and the shared Stack.
// slave is the arbiter's view; master is the combined requester/Stack side.
interface stack_arbiter_if #(
    parameter int WORD_RANGE = 8
);
    logic                  Req0;
    logic                  Req1;
    logic                  Op0;
    logic                  Op1;
    logic [WORD_RANGE-1:0] Wdata0;
    logic [WORD_RANGE-1:0] Wdata1;
    logic                  Ack0;
    logic                  Ack1;
    logic                  Err0;
    logic                  Err1;
    logic [WORD_RANGE-1:0] Rdata;
    logic                  Busy;
    logic                  Stk_Enable;
    logic                  Stk_Push;
    logic                  Stk_Pop;
    logic [WORD_RANGE-1:0] Stk_Data_in;
    logic [WORD_RANGE-1:0] Stk_Data_out;
    logic                  Stk_Full;
    logic                  Stk_Empty;

    modport slave (
        input  Req0, Req1, Op0, Op1, Wdata0, Wdata1,
        input  Stk_Data_out, Stk_Full, Stk_Empty,
        output Ack0, Ack1, Err0, Err1, Rdata, Busy,
        output Stk_Enable, Stk_Push, Stk_Pop, Stk_Data_in
    );

    modport master (
        output Req0, Req1, Op0, Op1, Wdata0, Wdata1,
        output Stk_Data_out, Stk_Full, Stk_Empty,
        input  Ack0, Ack1, Err0, Err1, Rdata, Busy,
        input  Stk_Enable, Stk_Push, Stk_Pop, Stk_Data_in
    );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one Stack between two requesters; every push/pop
// becomes a single Enable pulse, with Full/Empty checked before issuing.
module stack_arbiter #(
    parameter int WORD_RANGE = 8
) (
    input  logic           Clk,
    input  logic           RstN,
    stack_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  op_q, op_d;
    logic                  rr_last_q, rr_last_d;
    logic [WORD_RANGE-1:0] rdata_q, rdata_d;
    logic [WORD_RANGE-1:0] stk_data_in_q, stk_data_in_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;
    logic                  stk_enable_q, stk_enable_d;
    logic                  stk_push_q, stk_push_d;
    logic                  stk_pop_q, stk_pop_d;

    logic                  any_req;
    logic                  sel_gnt;
    logic                  sel_op;
    logic                  sel_illegal;
    logic [WORD_RANGE-1:0] sel_wdata;

    // A tie goes to whoever did not win last; Full/Empty are stable in IDLE.
    always_comb begin : arbitrate
        any_req = bus.Req0 | bus.Req1;
        if (bus.Req0 && bus.Req1) begin
            sel_gnt = ~rr_last_q;
        end else begin
            sel_gnt = bus.Req1;
        end
        sel_op      = sel_gnt ? bus.Op1 : bus.Op0;
        sel_wdata   = sel_gnt ? bus.Wdata1 : bus.Wdata0;
        sel_illegal = sel_op ? bus.Stk_Full : bus.Stk_Empty;
    end

    always_comb begin : next_state
        state_d       = state_q;
        gnt_d         = gnt_q;
        op_d          = op_q;
        rr_last_d     = rr_last_q;
        rdata_d       = rdata_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        stk_enable_d  = 1'b0;
        stk_push_d    = 1'b0;
        stk_pop_d     = 1'b0;
        stk_data_in_d = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d     = sel_gnt;
                    op_d      = sel_op;
                    rr_last_d = sel_gnt;
                    // Outputs are registered, so the ISSUE-cycle pins are loaded here.
                    if (sel_illegal) begin
                        state_d = RESP;
                        ack0_d  = ~sel_gnt;
                        ack1_d  = sel_gnt;
                        err0_d  = ~sel_gnt;
                        err1_d  = sel_gnt;
                    end else begin
                        state_d       = ISSUE;
                        stk_enable_d  = 1'b1;
                        stk_push_d    = sel_op;
                        stk_pop_d     = ~sel_op;
                        stk_data_in_d = sel_wdata;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!op_q) begin
                    rdata_d = bus.Stk_Data_out;
                end
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge RstN) begin : regs
        if (RstN) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            op_q          <= 1'b0;
            rr_last_q     <= 1'b1;
            rdata_q       <= '0;
            stk_data_in_q <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            stk_enable_q  <= 1'b0;
            stk_push_q    <= 1'b0;
            stk_pop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            op_q          <= op_d;
            rr_last_q     <= rr_last_d;
            rdata_q       <= rdata_d;
            stk_data_in_q <= stk_data_in_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            stk_enable_q  <= stk_enable_d;
            stk_push_q    <= stk_push_d;
            stk_pop_q     <= stk_pop_d;
        end
    end

    assign bus.Ack0        = ack0_q;
    assign bus.Ack1        = ack1_q;
    assign bus.Err0        = err0_q;
    assign bus.Err1        = err1_q;
    assign bus.Rdata       = rdata_q;
    assign bus.Busy        = (state_q != IDLE);
    assign bus.Stk_Enable  = stk_enable_q;
    assign bus.Stk_Push    = stk_push_q;
    assign bus.Stk_Pop     = stk_pop_q;
    assign bus.Stk_Data_in = stk_data_in_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a 64-deep stack stand-in, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_stack_arbiter;
    localparam int W     = 8;
    localparam int DEPTH = 64;

    logic Clk  = 1'b0;
    logic RstN = 1'b0;

    stack_arbiter_if #(.WORD_RANGE(W)) bus ();

    stack_arbiter #(.WORD_RANGE(W)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    int n_vec     = 0;
    int n_miss    = 0;
    int en_count  = 0;
    int ack_count = 0;

    // Stack stand-in: pops present the word on Data_out after the enabling edge.
    logic [W-1:0] stk_mem [DEPTH];
    logic [6:0]   stk_sp;
    logic [W-1:0] stk_dout;

    always @(posedge Clk or posedge RstN) begin
        if (RstN) begin
            stk_sp   <= '0;
            stk_dout <= '0;
        end else if (bus.Stk_Enable) begin
            if (bus.Stk_Push && stk_sp < 7'(DEPTH)) begin
                stk_mem[stk_sp[5:0]] <= bus.Stk_Data_in;
                stk_sp               <= stk_sp + 7'd1;
            end else if (bus.Stk_Pop && stk_sp != 7'd0) begin
                stk_dout <= stk_mem[6'(stk_sp - 7'd1)];
                stk_sp   <= stk_sp - 7'd1;
            end
        end
    end

    assign bus.Stk_Full     = (stk_sp == 7'(DEPTH));
    assign bus.Stk_Empty    = (stk_sp == 7'd0);
    assign bus.Stk_Data_out = stk_dout;

    // Reference model: each grant schedules the pins for the following cycles.
    typedef struct packed {
        logic         busy;
        logic         en;
        logic         push;
        logic         pop;
        logic [W-1:0] din;
        logic         ack0;
        logic         ack1;
        logic         err0;
        logic         err1;
        logic         set_rd;
        logic [W-1:0] rd;
    } exp_t;

    exp_t         sched [3];
    exp_t         exp_cur;
    logic [W-1:0] model_rdata;
    logic         last_winner;
    logic [W-1:0] ref_stack [$];

    always @(posedge Clk or posedge RstN) begin
        if (RstN) begin
            for (int k = 0; k < 3; k++) sched[k] = '0;
            exp_cur     = '0;
            model_rdata = '0;
            last_winner = 1'b1;
            ref_stack.delete();
        end else begin
            if (!exp_cur.busy && (bus.Req0 || bus.Req1)) begin
                logic         g;
                logic         op;
                logic [W-1:0] wd;
                logic         bad;
                g           = (bus.Req0 && bus.Req1) ? ~last_winner : bus.Req1;
                op          = g ? bus.Op1 : bus.Op0;
                wd          = g ? bus.Wdata1 : bus.Wdata0;
                last_winner = g;
                bad         = op ? (ref_stack.size() >= DEPTH) : (ref_stack.size() == 0);
                if (bad) begin
                    sched[0].busy = 1'b1;
                    sched[0].ack0 = ~g;
                    sched[0].ack1 = g;
                    sched[0].err0 = ~g;
                    sched[0].err1 = g;
                end else begin
                    sched[0].busy = 1'b1;
                    sched[0].en   = 1'b1;
                    sched[0].push = op;
                    sched[0].pop  = ~op;
                    sched[0].din  = wd;
                    sched[1].busy = 1'b1;
                    sched[2].busy = 1'b1;
                    sched[2].ack0 = ~g;
                    sched[2].ack1 = g;
                    if (op) begin
                        ref_stack.push_back(wd);
                    end else begin
                        sched[2].set_rd = 1'b1;
                        sched[2].rd     = ref_stack.pop_back();
                    end
                end
            end
            exp_cur  = sched[0];
            sched[0] = sched[1];
            sched[1] = sched[2];
            sched[2] = '0;
            if (exp_cur.set_rd) model_rdata = exp_cur.rd;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!RstN) begin
            checkOutput("Busy", 32'(bus.Busy), 32'(exp_cur.busy));
            checkOutput("Stk_Enable", 32'(bus.Stk_Enable), 32'(exp_cur.en));
            checkOutput("Stk_Push", 32'(bus.Stk_Push), 32'(exp_cur.push));
            checkOutput("Stk_Pop", 32'(bus.Stk_Pop), 32'(exp_cur.pop));
            checkOutput("Ack0", 32'(bus.Ack0), 32'(exp_cur.ack0));
            checkOutput("Ack1", 32'(bus.Ack1), 32'(exp_cur.ack1));
            checkOutput("Err0", 32'(bus.Err0), 32'(exp_cur.err0));
            checkOutput("Err1", 32'(bus.Err1), 32'(exp_cur.err1));
            checkOutput("Rdata", 32'(bus.Rdata), 32'(model_rdata));
            if (exp_cur.push || !exp_cur.en)
                checkOutput("Stk_Data_in", 32'(bus.Stk_Data_in), 32'(exp_cur.din));
        end
        if (bus.Stk_Enable) en_count++;
        if (bus.Ack0 || bus.Ack1) ack_count++;
    end

    task automatic applyStimulus(input logic r0, input logic o0, input logic [W-1:0] w0,
                                 input logic r1, input logic o1, input logic [W-1:0] w1);
        bus.Req0   = r0;
        bus.Op0    = o0;
        bus.Wdata0 = w0;
        bus.Req1   = r1;
        bus.Op1    = o1;
        bus.Wdata1 = w1;
    endtask

    task automatic waitAck(output int lat, output logic who);
        bit seen = 1'b0;
        lat = -1;
        who = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge Clk);
            if (bus.Ack0 || bus.Ack1) begin
                seen = 1'b1;
                lat  = i;
                who  = bus.Ack1;
            end
        end
        if (!seen) checkOutput("ack timeout", 32'd0, 32'd1);
    endtask

    task automatic doReq(input logic who, input logic op, input logic [W-1:0] wd, output int lat);
        logic w;
        @(negedge Clk);
        if (who) applyStimulus(1'b0, 1'b0, '0, 1'b1, op, wd);
        else     applyStimulus(1'b1, op, wd, 1'b0, 1'b0, '0);
        waitAck(lat, w);
        checkOutput("ack owner", 32'(w), 32'(who));
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic pulseReset();
        @(negedge Clk);
        RstN = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b0;
    endtask

    initial begin
        int   lat;
        int   e0;
        int   a0;
        logic who;

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1 RstN = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset Busy", 32'(bus.Busy), 32'd0);
        checkOutput("reset Ack0", 32'(bus.Ack0), 32'd0);
        checkOutput("reset Rdata", 32'(bus.Rdata), 32'd0);
        RstN = 1'b0;

        $display("[TB] push 0x5A from requester 0");
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, '0);
        @(negedge Clk);
        checkOutput("push Stk_Enable", 32'(bus.Stk_Enable), 32'd1);
        checkOutput("push Stk_Push", 32'(bus.Stk_Push), 32'd1);
        checkOutput("push Stk_Pop", 32'(bus.Stk_Pop), 32'd0);
        checkOutput("push Stk_Data_in", 32'(bus.Stk_Data_in), 32'h5A);
        @(negedge Clk);
        checkOutput("push pulse width", 32'(bus.Stk_Enable), 32'd0);
        checkOutput("push early Ack0", 32'(bus.Ack0), 32'd0);
        @(negedge Clk);
        checkOutput("push Ack0", 32'(bus.Ack0), 32'd1);
        checkOutput("push Err0", 32'(bus.Err0), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        $display("[TB] pop from requester 1");
        e0 = en_count;
        doReq(1'b1, 1'b0, '0, lat);
        checkOutput("pop latency", 32'(lat), 32'd3);
        checkOutput("pop Err1", 32'(bus.Err1), 32'd0);
        checkOutput("pop Rdata", 32'(bus.Rdata), 32'h5A);
        checkOutput("pop Stk_Empty", 32'(bus.Stk_Empty), 32'd1);
        checkOutput("pop pulse count", 32'(en_count - e0), 32'd1);

        $display("[TB] pop on empty stack");
        e0 = en_count;
        doReq(1'b1, 1'b0, '0, lat);
        checkOutput("empty pop latency", 32'(lat), 32'd1);
        checkOutput("empty pop Err1", 32'(bus.Err1), 32'd1);
        checkOutput("empty pop Rdata kept", 32'(bus.Rdata), 32'h5A);
        repeat (2) @(negedge Clk);
        checkOutput("empty pop no enable", 32'(en_count - e0), 32'd0);

        $display("[TB] reset mid-operation");
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, '0);
        @(negedge Clk);
        @(posedge Clk);
        #2 RstN = 1'b1;
        #1;
        checkOutput("midrst Busy", 32'(bus.Busy), 32'd0);
        checkOutput("midrst Stk_Enable", 32'(bus.Stk_Enable), 32'd0);
        checkOutput("midrst Ack0", 32'(bus.Ack0), 32'd0);
        checkOutput("midrst Rdata", 32'(bus.Rdata), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge Clk);
        RstN = 1'b0;
        a0 = ack_count;
        repeat (4) @(negedge Clk);
        checkOutput("midrst no Ack", 32'(ack_count - a0), 32'd0);

        $display("[TB] both requesters push, held");
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22);
        for (int k = 0; k < 4; k++) begin
            waitAck(lat, who);
            checkOutput("rr order", 32'(who), 32'(k % 2));
            checkOutput("rr Err", 32'(bus.Err0 | bus.Err1), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        doReq(1'b0, 1'b0, '0, lat);
        checkOutput("lifo first", 32'(bus.Rdata), 32'h22);
        doReq(1'b0, 1'b0, '0, lat);
        checkOutput("lifo second", 32'(bus.Rdata), 32'h11);

        $display("[TB] fill stack then overflow");
        pulseReset();
        for (int i = 0; i < DEPTH; i++) doReq(1'b0, 1'b1, 8'(i), lat);
        checkOutput("fill Stk_Full", 32'(bus.Stk_Full), 32'd1);
        e0 = en_count;
        doReq(1'b0, 1'b1, 8'hFF, lat);
        checkOutput("overflow latency", 32'(lat), 32'd1);
        checkOutput("overflow Err0", 32'(bus.Err0), 32'd1);
        checkOutput("overflow no enable", 32'(en_count - e0), 32'd0);

        $display("[TB] reset during ISSUE of a pop");
        @(negedge Clk);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(posedge Clk);
        #2;
        checkOutput("issue Stk_Enable", 32'(bus.Stk_Enable), 32'd1);
        checkOutput("issue Stk_Pop", 32'(bus.Stk_Pop), 32'd1);
        a0 = ack_count;
        RstN = 1'b1;
        #1;
        checkOutput("issue rst Stk_Enable", 32'(bus.Stk_Enable), 32'd0);
        checkOutput("issue rst Stk_Pop", 32'(bus.Stk_Pop), 32'd0);
        checkOutput("issue rst Busy", 32'(bus.Busy), 32'd0);
        checkOutput("issue rst Stk_Empty", 32'(bus.Stk_Empty), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge Clk);
        RstN = 1'b0;
        repeat (6) @(negedge Clk);
        checkOutput("issue rst no Ack", 32'(ack_count - a0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
